data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/mips_mem_pkg.sv | 21 ++
 rtl/arb_priority_pick.sv | 32 +++
 rtl/data_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared FSM type and port-index constants for data_mem_arbiter
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam int DEFAULT_MEM_DEPTH = 64;

  localparam int PORT_IFETCH = 0;
  localparam int PORT_LDST   = 1;

endpackage
`default_nettype wire

// File: rtl/arb_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_priority_pick
// Description : Two-port winner selection; the pointer names the port that
//               wins a tie. Purely combinational, one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_priority_pick
  import mips_mem_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_req0 && i_req1) begin
      if (i_ptr == 1'(PORT_LDST)) begin
        o_grant[PORT_LDST] = 1'b1;
      end else begin
        o_grant[PORT_IFETCH] = 1'b1;
      end
    end else begin
      o_grant[PORT_IFETCH] = i_req0;
      o_grant[PORT_LDST]   = i_req1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Arbitrates instruction-fetch (port 0) and load/store (port 1)
//               requesters onto one data memory; IDLE/ACCESS/RESP per access.
//               ARB_ROUND_ROBIN_EN selects round-robin tie resolution,
//               otherwise port 1 always wins a tie.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Write0,
  input  logic              Write1,
  input  logic [ADDR_W-1:0] Address0,
  input  logic [ADDR_W-1:0] Address1,
  input  logic [DATA_W-1:0] WriteData0,
  input  logic [DATA_W-1:0] WriteData1,
  output logic              Ack0,
  output logic              Ack1,
  output logic              Err0,
  output logic              Err1,
  output logic [DATA_W-1:0] ReadData0,
  output logic [DATA_W-1:0] ReadData1,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  input  logic [DATA_W-1:0] MemReadData
);

  arb_state_t        r_state;
  logic              r_winner;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic [1:0]        w_grant;
  logic              w_ptr;
  logic              w_in_range;
  logic              w_access;
  logic [DATA_W-1:0] w_load_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_ptr;

  // Tie priority moves to whichever port did not win the last grant.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_ptr <= 1'(PORT_IFETCH);
    end else if ((r_state == IDLE) && (|w_grant)) begin
      r_ptr <= ~w_grant[PORT_LDST];
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'(PORT_LDST);
`endif

  arb_priority_pick u_pick (
    .i_req0  (Req0),
    .i_req1  (Req1),
    .i_ptr   (w_ptr),
    .o_grant (w_grant)
  );

  assign w_in_range  = (r_addr < ADDR_W'(MEM_DEPTH));
  assign w_access    = (r_state == ACCESS) && w_in_range;
  assign w_load_data = w_in_range ? MemReadData : '0;

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_state  <= IDLE;
      r_winner <= 1'(PORT_IFETCH);
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant[PORT_LDST]) begin
            r_state  <= ACCESS;
            r_winner <= 1'(PORT_LDST);
            r_write  <= Write1;
            r_addr   <= Address1;
            r_wdata  <= WriteData1;
          end else if (w_grant[PORT_IFETCH]) begin
            r_state  <= ACCESS;
            r_winner <= 1'(PORT_IFETCH);
            r_write  <= Write0;
            r_addr   <= Address0;
            r_wdata  <= WriteData0;
          end
        end
        ACCESS: begin
          r_state <= RESP;
          if (!r_write) begin
            if (r_winner == 1'(PORT_LDST)) begin
              r_rdata1 <= w_load_data;
            end else begin
              r_rdata0 <= w_load_data;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Memory bus is forced to zero outside an in-range ACCESS cycle.
  assign MemRead      = w_access && !r_write;
  assign MemWrite     = w_access && r_write;
  assign MemAddress   = w_access ? r_addr : '0;
  assign MemWriteData = (w_access && r_write) ? r_wdata : '0;

  assign Ack0 = (r_state == RESP) && (r_winner == 1'(PORT_IFETCH));
  assign Ack1 = (r_state == RESP) && (r_winner == 1'(PORT_LDST));
  assign Err0 = Ack0 && !w_in_range;
  assign Err1 = Ack1 && !w_in_range;

  assign ReadData0 = r_rdata0;
  assign ReadData1 = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Scoreboard bench for data_mem_arbiter with a behavioural
//               memory/arbitration model. Honors ARB_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 64;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          ResetN;
  logic          Req0, Req1, Write0, Write1;
  logic [AW-1:0] Address0, Address1;
  logic [DW-1:0] WriteData0, WriteData1;
  logic          Ack0, Ack1, Err0, Err1;
  logic [DW-1:0] ReadData0, ReadData1;
  logic          MemRead, MemWrite;
  logic [AW-1:0] MemAddress;
  logic [DW-1:0] MemWriteData;
  logic [DW-1:0] MemReadData;

  always #5 Clock = ~Clock;

  data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
    .Clock(Clock), .ResetN(ResetN),
    .Req0(Req0), .Req1(Req1), .Write0(Write0), .Write1(Write1),
    .Address0(Address0), .Address1(Address1),
    .WriteData0(WriteData0), .WriteData1(WriteData1),
    .Ack0(Ack0), .Ack1(Ack1), .Err0(Err0), .Err1(Err1),
    .ReadData0(ReadData0), .ReadData1(ReadData1),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemReadData(MemReadData)
  );

  // Memory the DUT talks to, and the reference copy the model predicts from.
  logic [DW-1:0] mem       [DEPTH];
  logic [DW-1:0] model_mem [DEPTH];
  logic          load_mem;

  always @(posedge Clock) begin
    if (load_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= model_mem[i];
    end else if (MemWrite && (MemAddress < DEPTH)) begin
      mem[MemAddress[5:0]] <= MemWriteData;
    end
  end

  always_comb begin
    MemReadData = '0;
    if (MemRead && (MemAddress < DEPTH)) MemReadData = mem[MemAddress[5:0]];
  end

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int            port;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            err;
    logic [DW-1:0] rdata;
    int            lat;
    int            issue_cyc;
  } txn_t;

  txn_t sbq[$];
  bit   rr_prio = 1'b0;   // port favoured on a tie in round-robin mode

  task automatic expect_txn(input int port, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int lat);
    txn_t t;
    t.port = port; t.wr = wr; t.addr = a; t.wdata = d; t.lat = lat;
    t.issue_cyc = cyc;
    t.err   = (a >= DEPTH);
    t.rdata = (wr || t.err) ? '0 : model_mem[a[5:0]];
    if (wr && !t.err) model_mem[a[5:0]] = d;
    sbq.push_back(t);
    rr_prio = (port == 0);
  endtask

  task automatic drive(input int port, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (port == 0) begin
      Req0 = 1'b1; Write0 = wr; Address0 = a; WriteData0 = d;
    end else begin
      Req1 = 1'b1; Write1 = wr; Address1 = a; WriteData1 = d;
    end
  endtask

  // Requester side: drop Req in the Ack cycle, then return in the next IDLE.
  task automatic wait_acks(input int n);
    int got = 0;
    int budget = 0;
    while (got < n && budget < 20) begin
      @(posedge Clock); #1;
      budget++;
      if (Ack0) begin Req0 = 1'b0; got++; end
      if (Ack1) begin Req1 = 1'b0; got++; end
    end
    if (got < n) begin
      n_total++;
      $display("FAIL ack_timeout: actual %0d acks required %0d", got, n);
      Req0 = 1'b0; Req1 = 1'b0;
    end
    @(posedge Clock); #1;
  endtask

  task automatic run_single(input int port, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(port, wr, a, d);
    expect_txn(port, wr, a, d, 2);
    wait_acks(1);
  endtask

  task automatic run_pair(input bit wr0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input bit wr1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int first;
    drive(0, wr0, a0, d0);
    drive(1, wr1, a1, d1);
    first = RR ? int'(rr_prio) : 1;
    if (first == 0) begin
      expect_txn(0, wr0, a0, d0, 2);
      expect_txn(1, wr1, a1, d1, 5);
    end else begin
      expect_txn(1, wr1, a1, d1, 2);
      expect_txn(0, wr0, a0, d0, 5);
    end
    wait_acks(2);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"},    {Ack0, Ack1}, 0);
    chk({tag, "_err"},    {Err0, Err1}, 0);
    chk({tag, "_strobe"}, {MemRead, MemWrite}, 0);
    chk({tag, "_maddr"},  MemAddress, 0);
    chk({tag, "_mwdata"}, MemWriteData, 0);
    chk({tag, "_rdata0"}, ReadData0, 0);
    chk({tag, "_rdata1"}, ReadData1, 0);
    chk({tag, "_fsm"},    dut.r_state, IDLE);
  endtask

  // Monitor: bus protocol every cycle, scoreboard pop on every Ack.
  int            rd_cnt = 0, wr_cnt = 0;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] exp_rd [2];
  txn_t          mt;

  always @(negedge Clock) begin
    if (!ResetN) begin
      rd_cnt = 0; wr_cnt = 0;
      exp_rd[0] = '0; exp_rd[1] = '0;
    end else begin
      chk("strobe_exclusive", MemRead && MemWrite, 0);
      if (!MemRead && !MemWrite) chk("idle_bus_zero", {MemAddress, MemWriteData}, 0);
      if (MemRead)  begin rd_cnt++; s_addr = MemAddress; end
      if (MemWrite) begin wr_cnt++; s_addr = MemAddress; s_wdata = MemWriteData; end
      if (Ack0 || Ack1) begin
        chk("ack_onehot", Ack0 && Ack1, 0);
        if (sbq.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_ack: actual ack0=%0d ack1=%0d required none", Ack0, Ack1);
        end else begin
          mt = sbq.pop_front();
          chk("ack_port", Ack1 ? 1 : 0, mt.port);
          chk("latency", cyc - mt.issue_cyc, mt.lat);
          chk("err", Ack1 ? Err1 : Err0, mt.err);
          chk("rd_strobes", rd_cnt, (!mt.err && !mt.wr) ? 1 : 0);
          chk("wr_strobes", wr_cnt, (!mt.err && mt.wr) ? 1 : 0);
          if (!mt.err) chk("strobe_addr", s_addr, mt.addr);
          if (!mt.err && mt.wr) chk("store_data", s_wdata, mt.wdata);
          if (!mt.wr) begin
            chk("load_data", (mt.port == 1) ? ReadData1 : ReadData0, mt.rdata);
            exp_rd[mt.port] = mt.rdata;
          end
          chk("rdata_hold", (mt.port == 1) ? ReadData0 : ReadData1, exp_rd[1 - mt.port]);
        end
        rd_cnt = 0; wr_cnt = 0;
      end
    end
  end

  logic [DW-1:0] rst_data;
  logic [AW-1:0] a;
  int            mode;

  initial begin
    ResetN = 1'b0; load_mem = 1'b0;
    Req0 = 1'b0; Req1 = 1'b0; Write0 = 1'b0; Write1 = 1'b0;
    Address0 = '0; Address1 = '0; WriteData0 = '0; WriteData1 = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = $urandom;
    model_mem[2] = 32'hFFFF_FFFB;
    load_mem = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    load_mem = 1'b0;
    check_all_zero("reset");
    ResetN = 1'b1;
    @(posedge Clock); #1;

    run_single(0, 1'b0, 2, 0);
    run_single(1, 1'b1, 5, 32'h1234_5678);
    run_single(1, 1'b0, 5, 0);
    run_single(1, 1'b0, 64, 0);

    // Reset while a port-0 store is in ACCESS: abandoned without Ack.
    rst_data = $urandom;
    drive(0, 1'b1, 10, rst_data);
    model_mem[10] = rst_data;
    @(posedge Clock); #1;
    chk("pre_reset_access_strobe", MemWrite, 1);
    ResetN = 1'b0; Req0 = 1'b0;
    @(posedge Clock); #1;
    check_all_zero("mid_access_reset");
    ResetN = 1'b1;
    rr_prio = 1'b0;

    run_pair(1'b0, 3, 0, 1'b0, 40, 0);
    run_single(0, 1'b1, 10, rst_data);
    run_single(1, 1'b0, 10, 0);

    for (int it = 0; it < 120; it++) begin
      mode = $urandom_range(0, 2);
      if (mode == 2) begin
        run_pair($urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(32, 71), $urandom);
      end else begin
        a = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h8000_0000) : $urandom_range(0, 70);
        run_single(mode, $urandom_range(0, 1) == 1, a, $urandom);
      end
      repeat ($urandom_range(0, 2)) @(posedge Clock);
    end

    repeat (4) @(posedge Clock);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
